// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: clears every register after reset or init,
// then shares the port round-robin between two valid/ready write requesters.
module regfile_write_arbiter #(
  parameter int wAddr = 2,
  parameter int wData = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             req0_valid,
  input  logic [wAddr-1:0] req0_addr,
  input  logic [wData-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [wAddr-1:0] req1_addr,
  input  logic [wData-1:0] req1_data,
  output logic             req1_ready,
  output logic             we,
  output logic [wAddr-1:0] wa,
  output logic [wData-1:0] wd,
  output logic             busy,
  output logic             dbg_state
);

  // Handshake: a request is accepted in any cycle where valid && ready; ready is
  // combinational, the requester holds valid/addr/data stable until it sees ready,
  // and every accepted request is written on the very next edge.

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Counter is one bit wider than the address so the last-address compare never wraps.
  localparam logic [wAddr:0] LP_LAST = {1'b0, {wAddr{1'b1}}};
  localparam logic [wAddr:0] LP_ONE  = {{wAddr{1'b0}}, 1'b1};

  state_t           r_state;
  logic [wAddr:0]   r_cnt;
  logic             r_last_grant;
  logic             r_we;
  logic [wAddr-1:0] r_wa;
  logic [wData-1:0] r_wd;
  logic             r_busy;

  logic w_run;
  logic w_gnt0;
  logic w_gnt1;
  logic w_acc0;
  logic w_acc1;

  assign w_run = (r_state == ST_RUN);

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt0 = r_last_grant;
      w_gnt1 = !r_last_grant;
    end else begin
      w_gnt0 = req0_valid;
      w_gnt1 = req1_valid;
    end
  end

  assign req0_ready = w_run && !init && w_gnt0;
  assign req1_ready = w_run && !init && w_gnt1;
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_wa         <= '0;
      r_wd         <= '0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (init) begin
            r_cnt <= '0;
            r_we  <= 1'b0;
          end else begin
            r_we  <= 1'b1;
            r_wa  <= r_cnt[wAddr-1:0];
            r_wd  <= '0;
            r_cnt <= r_cnt + LP_ONE;
            if (r_cnt == LP_LAST) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (init) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_we    <= 1'b0;
          end else if (w_acc0 || w_acc1) begin
            r_we         <= 1'b1;
            r_wa         <= w_acc0 ? req0_addr : req1_addr;
            r_wd         <= w_acc0 ? req0_data : req1_data;
            r_last_grant <= w_acc1;
          end else begin
            r_we <= 1'b0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign we        = r_we;
  assign wa        = r_wa;
  assign wd        = r_wd;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (wAddr=2, wData=4): clear sweep,
// single and back-to-back writes, round-robin ties, init in RUN, async reset.
module tb_regfile_write_arbiter;

  logic       clock;
  logic       reset;
  logic       init;
  logic       req0_valid;
  logic [1:0] req0_addr;
  logic [3:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_addr;
  logic [3:0] req1_data;
  logic       req1_ready;
  logic       we;
  logic [1:0] wa;
  logic [3:0] wd;
  logic       busy;
  logic       dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] rf [4];

  regfile_write_arbiter #(.wAddr(2), .wData(4)) dut (
    .clock(clock), .reset(reset), .init(init),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .we(we), .wa(wa), .wd(wd), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model fed by the write port
  always @(posedge clock) if (we) rf[wa] <= wd;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    init       = 1'b0;
    req0_valid = 1'b0;
    req0_addr  = 2'd0;
    req0_data  = 4'h0;
    req1_valid = 1'b0;
    req1_addr  = 2'd0;
    req1_data  = 4'h0;
  endtask

  // Reset values, then the full clear sweep with both requesters pending
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    n_cmp++;
    if ({we, wa, wd, busy, dbg_state} !== {1'b1 ^ 1'b1, 2'd0, 4'h0, 1'b1, 1'b0}) begin
      $display("FAIL reset_values got we=%b wa=%0d wd=%h busy=%b st=%b want 0 0 0 1 0",
               we, wa, wd, busy, dbg_state);
      n_fail++;
    end
    tick();
    reset      = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 2'd1;
    req0_data  = 4'h9;
    req1_valid = 1'b1;
    req1_addr  = 2'd2;
    req1_data  = 4'h9;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        $display("FAIL clear_ready[%0d] got %b%b want 00", i, req0_ready, req1_ready);
        n_fail++;
      end
      tick();
      n_cmp++;
      if ({we, wa, wd, busy} !== {1'b1, 2'(i), 4'h0, (i < 3)}) begin
        $display("FAIL clear_sweep[%0d] got we=%b wa=%0d wd=%h busy=%b want 1 %0d 0 %b",
                 i, we, wa, wd, busy, i, (i < 3));
        n_fail++;
      end
    end
    n_cmp++;
    if (dbg_state !== 1'b1) begin
      $display("FAIL clear_to_run got st=%b want 1", dbg_state);
      n_fail++;
    end
    idle_inputs();
  endtask

  // Single req0 write: ready same cycle, write next cycle, idle after
  task automatic test_single_write();
    req0_valid = 1'b1;
    req0_addr  = 2'd2;
    req0_data  = 4'hA;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready);
      n_fail++;
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({we, wa, wd} !== {1'b1, 2'd2, 4'hA}) begin
      $display("FAIL single_write got we=%b wa=%0d wd=%h want 1 2 a", we, wa, wd);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({we, wa, wd} !== {1'b0, 2'd2, 4'hA}) begin
      $display("FAIL single_idle got we=%b wa=%0d wd=%h want 0 2 a", we, wa, wd);
      n_fail++;
    end
  endtask

  // req1 alone for four cycles: four back-to-back writes one cycle later
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1;
      req1_addr  = 2'(i);
      req1_data  = 4'(8 + i);
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        $display("FAIL b2b_ready[%0d] got %b%b want 01", i, req0_ready, req1_ready);
        n_fail++;
      end
      tick();
      n_cmp++;
      if ({we, wa, wd} !== {1'b1, 2'(i), 4'(8 + i)}) begin
        $display("FAIL b2b_write[%0d] got we=%b wa=%0d wd=%h want 1 %0d %h",
                 i, we, wa, wd, i, 8 + i);
        n_fail++;
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (we !== 1'b0) begin
      $display("FAIL b2b_idle got we=%b want 0", we);
      n_fail++;
    end
  endtask

  // Both requesters contend: grants alternate 0,1,0,1,0,1
  task automatic test_round_robin();
    logic [3:0] d0 [3];
    logic [3:0] d1 [3];
    int i0;
    int i1;
    int g;
    d0 = '{4'h5, 4'h6, 4'h7};
    d1 = '{4'hC, 4'hD, 4'hE};
    i0 = 0;
    i1 = 0;
    req0_addr = 2'd1;
    req1_addr = 2'd3;
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      req0_valid = (i0 < 3);
      req0_data  = (i0 < 3) ? d0[i0] : 4'h0;
      req1_valid = (i1 < 3);
      req1_data  = (i1 < 3) ? d1[i1] : 4'h0;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin
        $display("FAIL rr_grant[%0d] got %b%b want grant %0d", k, req0_ready, req1_ready, g);
        n_fail++;
      end
      tick();
      n_cmp++;
      if (g == 0) begin
        if ({we, wa, wd} !== {1'b1, 2'd1, d0[i0]}) begin
          $display("FAIL rr_write[%0d] got we=%b wa=%0d wd=%h want 1 1 %h", k, we, wa, wd, d0[i0]);
          n_fail++;
        end
        i0++;
      end else begin
        if ({we, wa, wd} !== {1'b1, 2'd3, d1[i1]}) begin
          $display("FAIL rr_write[%0d] got we=%b wa=%0d wd=%h want 1 3 %h", k, we, wa, wd, d1[i1]);
          n_fail++;
        end
        i1++;
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if ({rf[1], rf[3]} !== {4'h7, 4'hE}) begin
      $display("FAIL rr_file got r1=%h r3=%h want 7 e", rf[1], rf[3]);
      n_fail++;
    end
  endtask

  // init in RUN blocks req0, forces a sweep, then req0 goes through
  task automatic test_init_in_run();
    req0_valid = 1'b1;
    req0_addr  = 2'd1;
    req0_data  = 4'h3;
    init       = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0) begin
      $display("FAIL init_block got ready=%b want 0", req0_ready);
      n_fail++;
    end
    tick();
    init = 1'b0;
    n_cmp++;
    if ({we, busy, dbg_state} !== 3'b010) begin
      $display("FAIL init_enter got we=%b busy=%b st=%b want 0 1 0", we, busy, dbg_state);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (req0_ready !== 1'b0) begin
        $display("FAIL init_sweep_ready[%0d] got %b want 0", i, req0_ready);
        n_fail++;
      end
      tick();
      n_cmp++;
      if ({we, wa, wd, busy} !== {1'b1, 2'(i), 4'h0, (i < 3)}) begin
        $display("FAIL init_sweep[%0d] got we=%b wa=%0d wd=%h busy=%b want 1 %0d 0 %b",
                 i, we, wa, wd, busy, i, (i < 3));
        n_fail++;
      end
    end
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      $display("FAIL init_resume_ready got %b want 1", req0_ready);
      n_fail++;
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({we, wa, wd} !== {1'b1, 2'd1, 4'h3}) begin
      $display("FAIL init_resume_write got we=%b wa=%0d wd=%h want 1 1 3", we, wa, wd);
      n_fail++;
    end
  endtask

  // Async reset just after wa=2 is loaded, then a fresh sweep from 0
  task automatic test_reset_mid_clear();
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if ({we, wa, busy} !== {1'b1, 2'd2, 1'b1}) begin
      $display("FAIL midclr_pre got we=%b wa=%0d busy=%b want 1 2 1", we, wa, busy);
      n_fail++;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({we, wa, wd, busy, dbg_state} !== {1'b0, 2'd0, 4'h0, 1'b1, 1'b0}) begin
      $display("FAIL midclr_async got we=%b wa=%0d wd=%h busy=%b st=%b want 0 0 0 1 0",
               we, wa, wd, busy, dbg_state);
      n_fail++;
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({we, wa, wd, busy} !== {1'b1, 2'(i), 4'h0, (i < 3)}) begin
        $display("FAIL midclr_sweep[%0d] got we=%b wa=%0d wd=%h busy=%b want 1 %0d 0 %b",
                 i, we, wa, wd, busy, i, (i < 3));
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_round_robin();
    test_init_in_run();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
